// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: datapath widths, ALU codes, operand-select
// encodings, packed control bit positions and the ID/EX register layout.
package riscv_pkg;

    localparam int XLEN             = 32;
    localparam int REG_ADDR_WIDTH   = 5;
    localparam int OPCODE_WIDTH     = 7;
    localparam int FUNCT3_WIDTH     = 3;
    localparam int ALUCONTROL_WIDTH = 6;
    localparam int CTRL_WIDTH       = 6;

    typedef logic [XLEN-1:0]             xlen_t;
    typedef logic [REG_ADDR_WIDTH-1:0]   reg_addr_t;
    typedef logic [OPCODE_WIDTH-1:0]     opcode_t;
    typedef logic [FUNCT3_WIDTH-1:0]     funct3_t;
    typedef logic [ALUCONTROL_WIDTH-1:0] alu_ctrl_t;
    typedef logic [CTRL_WIDTH-1:0]       ctrl_t;

    // ALU operation codes; ADD must stay 0 so a bubble is an all-zero word.
    localparam alu_ctrl_t ALU_ADD = 6'd0;
    localparam alu_ctrl_t ALU_SUB = 6'd1;
    localparam alu_ctrl_t ALU_AND = 6'd2;
    localparam alu_ctrl_t ALU_OR  = 6'd3;
    localparam alu_ctrl_t ALU_XOR = 6'd4;
    localparam alu_ctrl_t ALU_SLT = 6'd5;

    // opA select; value 3 is reserved and produces zero.
    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    // opB select.
    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    // Packed control: {RegWrite, MemWrite, Jump, Branch, ResultSrc[1:0]}.
    localparam int CTRL_REG_WRITE = 5;
    localparam int CTRL_MEM_WRITE = 4;
    localparam int CTRL_JUMP      = 3;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_RES_HI    = 1;
    localparam int CTRL_RES_LO    = 0;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    // Everything the E stage remembers about one instruction.
    typedef struct packed {
        xlen_t      rs1_data;
        xlen_t      rs2_data;
        xlen_t      imm_ext;
        xlen_t      pc;
        xlen_t      pc_plus4;
        reg_addr_t  rs1;
        reg_addr_t  rs2;
        reg_addr_t  rd;
        opcode_t    opcode;
        funct3_t    funct3;
        alu_ctrl_t  alu_ctrl;
        logic [1:0] src_a;
        logic       src_b;
        ctrl_t      ctrl;
        logic       valid;
    } ex_reg_t;

    // A bubble: no write-back, no memory access, ADD, not valid.
    localparam ex_reg_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode inputs, forwarding sources and E-stage outputs around the
// ID/EX register. The pipeline drives through master; the stage is the slave.
interface id_ex_stage_if;
    import riscv_pkg::*;

    // Pipeline control
    logic       stall_E;
    logic       flush_E;

    // Decode-side fields
    xlen_t      rs1_data_D;
    xlen_t      rs2_data_D;
    xlen_t      imm_ext_D;
    xlen_t      PC_D;
    reg_addr_t  rs1_D;
    reg_addr_t  rs2_D;
    reg_addr_t  rd_D;
    opcode_t    opcode_D;
    funct3_t    funct3_D;
    alu_ctrl_t  ALUControl_D;
    logic [1:0] ALUSrcA_D;
    logic       ALUSrcB_D;
    ctrl_t      ctrl_D;

    // Forwarding sources
    xlen_t      ALU_result_M;
    reg_addr_t  rd_M;
    logic       RegWrite_M;
    xlen_t      result_W;
    reg_addr_t  rd_W;
    logic       RegWrite_W;

    // Execute-side results
    xlen_t      opA;
    xlen_t      opB;
    alu_ctrl_t  ALUControl_E;
    opcode_t    opcode_E;
    funct3_t    funct3_E;
    xlen_t      write_data_E;
    xlen_t      PC_E;
    xlen_t      PC_plus4_E;
    xlen_t      imm_ext_E;
    reg_addr_t  rs1_E;
    reg_addr_t  rs2_E;
    reg_addr_t  rd_E;
    ctrl_t      ctrl_E;
    logic       valid_E;
    logic       lw_stall;

    modport master (
        output stall_E, flush_E,
        output rs1_data_D, rs2_data_D, imm_ext_D, PC_D, rs1_D, rs2_D, rd_D,
        output opcode_D, funct3_D, ALUControl_D, ALUSrcA_D, ALUSrcB_D, ctrl_D,
        output ALU_result_M, rd_M, RegWrite_M, result_W, rd_W, RegWrite_W,
        input  opA, opB, ALUControl_E, opcode_E, funct3_E, write_data_E,
        input  PC_E, PC_plus4_E, imm_ext_E, rs1_E, rs2_E, rd_E, ctrl_E,
        input  valid_E, lw_stall
    );

    modport slave (
        input  stall_E, flush_E,
        input  rs1_data_D, rs2_data_D, imm_ext_D, PC_D, rs1_D, rs2_D, rd_D,
        input  opcode_D, funct3_D, ALUControl_D, ALUSrcA_D, ALUSrcB_D, ctrl_D,
        input  ALU_result_M, rd_M, RegWrite_M, result_W, rd_W, RegWrite_W,
        output opA, opB, ALUControl_E, opcode_E, funct3_E, write_data_E,
        output PC_E, PC_plus4_E, imm_ext_E, rs1_E, rs2_E, rd_E, ctrl_E,
        output valid_E, lw_stall
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register: MEM beats WB beats the value
// read from the register file; x0 is never forwarded.
module fwd_mux
    import riscv_pkg::*;
(
    input  reg_addr_t rs_addr,
    input  reg_addr_t rd_M,
    input  logic      reg_write_M,
    input  xlen_t     value_M,
    input  reg_addr_t rd_W,
    input  logic      reg_write_W,
    input  xlen_t     value_W,
    input  xlen_t     reg_value,
    output xlen_t     fwd_value
);

    logic hit_M;
    logic hit_W;

    assign hit_M = reg_write_M && (rd_M != '0) && (rd_M == rs_addr);
    assign hit_W = reg_write_W && (rd_W != '0) && (rd_W == rs_addr);

    // Pick the youngest in-flight producer of this register.
    always_comb begin
        // NOTE: a default on every path of a combinational block keeps it from inferring a latch.
        fwd_value = reg_value;
        if (hit_M) begin
            fwd_value = value_M;
        end else if (hit_W) begin
            fwd_value = value_W;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with the EX operand forwarding network and the
// load-use stall request for the hazard unit.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    ex_reg_t e_d;
    ex_reg_t e_q;
    xlen_t   fwd_rs1;
    xlen_t   fwd_rs2;

    // Gather the decode fields into next-state form; PC+4 wraps at 2^XLEN.
    always_comb begin
        e_d          = EX_BUBBLE;
        e_d.rs1_data = bus.rs1_data_D;
        e_d.rs2_data = bus.rs2_data_D;
        e_d.imm_ext  = bus.imm_ext_D;
        e_d.pc       = bus.PC_D;
        e_d.pc_plus4 = bus.PC_D + xlen_t'(4);
        e_d.rs1      = bus.rs1_D;
        e_d.rs2      = bus.rs2_D;
        e_d.rd       = bus.rd_D;
        e_d.opcode   = bus.opcode_D;
        e_d.funct3   = bus.funct3_D;
        e_d.alu_ctrl = bus.ALUControl_D;
        e_d.src_a    = bus.ALUSrcA_D;
        e_d.src_b    = bus.ALUSrcB_D;
        e_d.ctrl     = bus.ctrl_D;
        e_d.valid    = 1'b1;
    end

    // E register: flush inserts a bubble, stall holds, otherwise load.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            e_q <= EX_BUBBLE;
        end else if (bus.flush_E) begin
            e_q <= EX_BUBBLE;
        end else if (!bus.stall_E) begin
            e_q <= e_d;
        end
    end

    fwd_mux u_fwd_rs1 (
        .rs_addr     (e_q.rs1),
        .rd_M        (bus.rd_M),
        .reg_write_M (bus.RegWrite_M),
        .value_M     (bus.ALU_result_M),
        .rd_W        (bus.rd_W),
        .reg_write_W (bus.RegWrite_W),
        .value_W     (bus.result_W),
        .reg_value   (e_q.rs1_data),
        .fwd_value   (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .rs_addr     (e_q.rs2),
        .rd_M        (bus.rd_M),
        .reg_write_M (bus.RegWrite_M),
        .value_M     (bus.ALU_result_M),
        .rd_W        (bus.rd_W),
        .reg_write_W (bus.RegWrite_W),
        .value_W     (bus.result_W),
        .reg_value   (e_q.rs2_data),
        .fwd_value   (fwd_rs2)
    );

    // ALU operand A: forwarded rs1, PC or zero (reserved select also gives zero).
    always_comb begin
        bus.opA = '0;
        case (e_q.src_a)
            SRC_A_RS1: bus.opA = fwd_rs1;
            SRC_A_PC:  bus.opA = e_q.pc;
            default:   bus.opA = '0;
        endcase
    end

    assign bus.opB          = (e_q.src_b == SRC_B_IMM) ? e_q.imm_ext : fwd_rs2;
    assign bus.write_data_E = fwd_rs2;

    assign bus.ALUControl_E = e_q.alu_ctrl;
    assign bus.opcode_E     = e_q.opcode;
    assign bus.funct3_E     = e_q.funct3;
    assign bus.PC_E         = e_q.pc;
    assign bus.PC_plus4_E   = e_q.pc_plus4;
    assign bus.imm_ext_E    = e_q.imm_ext;
    assign bus.rs1_E        = e_q.rs1;
    assign bus.rs2_E        = e_q.rs2;
    assign bus.rd_E         = e_q.rd;
    assign bus.ctrl_E       = e_q.ctrl;
    assign bus.valid_E      = e_q.valid;

    // Load in E whose destination the instruction in D still needs to read.
    always_comb begin
        bus.lw_stall = 1'b0;
        if (e_q.valid
            && (e_q.ctrl[CTRL_RES_HI:CTRL_RES_LO] == RES_LOAD)
            && (e_q.rd != '0)
            && ((e_q.rd == bus.rs1_D) || (e_q.rd == bus.rs2_D))) begin
            bus.lw_stall = 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a scoreboard queue holds the expected
// E-stage view of every driven cycle; forwarding and load-use are probed
// combinationally between edges.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] opA;
        logic [31:0] opB;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [5:0]  alu;
        logic [5:0]  ctrl;
        logic [4:0]  rd;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_fwd();
        bus.ALU_result_M = '0;
        bus.rd_M         = '0;
        bus.RegWrite_M   = 1'b0;
        bus.result_W     = '0;
        bus.rd_W         = '0;
        bus.RegWrite_W   = 1'b0;
    endtask

    // Drive one decoded instruction and queue what E must show after the edge.
    task automatic drive(input logic [31:0] rs1v, input logic [31:0] rs2v,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [1:0] sa, input logic sb,
                         input logic [5:0] alu, input logic [5:0] ctrl);
        exp_t e;
        bus.rs1_data_D   = rs1v;
        bus.rs2_data_D   = rs2v;
        bus.imm_ext_D    = imm;
        bus.PC_D         = pc;
        bus.rs1_D        = rs1;
        bus.rs2_D        = rs2;
        bus.rd_D         = rd;
        bus.ALUSrcA_D    = sa;
        bus.ALUSrcB_D    = sb;
        bus.ALUControl_D = alu;
        bus.ctrl_D       = ctrl;
        bus.opcode_D     = 7'h13;
        bus.funct3_D     = 3'h5;
        e.opA   = (sa == 2'd0) ? rs1v : (sa == 2'd1) ? pc : 32'h0;
        e.opB   = sb ? imm : rs2v;
        e.wd    = rs2v;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        e.alu   = alu;
        e.ctrl  = ctrl;
        e.rd    = rd;
        e.valid = 1'b1;
        exp_q.push_back(e);
        last_exp = e;
    endtask

    task automatic hold_expect();
        exp_q.push_back(last_exp);
    endtask

    task automatic bubble_expect();
        exp_t e;
        e.opA = '0; e.opB = '0; e.wd = '0; e.pc = '0; e.pc4 = '0;
        e.alu = '0; e.ctrl = '0; e.rd = '0; e.valid = 1'b0;
        exp_q.push_back(e);
        last_exp = e;
    endtask

    task automatic check_e(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, ".sb_underflow"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".opA"},   bus.opA,          e.opA);
        check({tag, ".opB"},   bus.opB,          e.opB);
        check({tag, ".wd"},    bus.write_data_E, e.wd);
        check({tag, ".pc"},    bus.PC_E,         e.pc);
        check({tag, ".pc4"},   bus.PC_plus4_E,   e.pc4);
        check({tag, ".alu"},   32'(bus.ALUControl_E), 32'(e.alu));
        check({tag, ".ctrl"},  32'(bus.ctrl_E),  32'(e.ctrl));
        check({tag, ".rd"},    32'(bus.rd_E),    32'(e.rd));
        check({tag, ".valid"}, 32'(bus.valid_E), 32'(e.valid));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.stall_E = 1'b0;
        bus.flush_E = 1'b0;
        bus.rs1_data_D = 32'h1234; bus.rs2_data_D = 32'h5678; bus.imm_ext_D = 32'h9;
        bus.PC_D = 32'h40; bus.rs1_D = 5'd1; bus.rs2_D = 5'd2; bus.rd_D = 5'd3;
        bus.opcode_D = 7'h33; bus.funct3_D = 3'h1; bus.ALUControl_D = 6'd2;
        bus.ALUSrcA_D = 2'd0; bus.ALUSrcB_D = 1'b0; bus.ctrl_D = 6'b100001;
        clear_fwd();

        // Reset held across an edge: everything zero.
        #12;
        check("rst.opA",   bus.opA, 32'h0);
        check("rst.valid", 32'(bus.valid_E), 32'h0);
        check("rst.alu",   32'(bus.ALUControl_E), 32'h0);
        check("rst.pc4",   bus.PC_plus4_E, 32'h0);
        check("rst.ctrl",  32'(bus.ctrl_E), 32'h0);
        check("rst.lw",    32'(bus.lw_stall), 32'h0);
        rst = 1'b0;

        // Plain load, opB from immediate.
        drive(32'd5, 32'd9, 32'd7, 32'h100, 5'd1, 5'd2, 5'd3, SRC_A_RS1, SRC_B_IMM, 6'd3, 6'b100000);
        tick();
        check_e("load1");
        check("load1.opcode", 32'(bus.opcode_E), 32'h13);
        check("load1.funct3", 32'(bus.funct3_E), 32'h5);
        check("load1.imm",    bus.imm_ext_E, 32'd7);

        // PC select and PC+4 wrap.
        drive(32'h12, 32'h22, 32'h40, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd3, SRC_A_PC, SRC_B_RS2, 6'd1, 6'b100000);
        tick();
        check_e("pc_wrap");
        check("pc_wrap.pc4_zero", bus.PC_plus4_E, 32'h0);

        drive(32'h12, 32'h22, 32'h40, 32'h200, 5'd1, 5'd2, 5'd3, SRC_A_ZERO, SRC_B_IMM, 6'd4, 6'b000100);
        tick();
        check_e("srca_zero");
        drive(32'h12, 32'h22, 32'h40, 32'h204, 5'd1, 5'd2, 5'd3, 2'd3, SRC_B_IMM, 6'd5, 6'b010000);
        tick();
        check_e("srca_rsvd");

        // Forwarding priority on rs1; x0 on rs2.
        drive(32'h11, 32'h55, 32'h0, 32'h300, 5'd3, 5'd0, 5'd7, SRC_A_RS1, SRC_B_RS2, 6'd0, 6'b100000);
        tick();
        check_e("fwd_base");
        bus.stall_E = 1'b1;
        bus.rd_M = 5'd3; bus.RegWrite_M = 1'b1; bus.ALU_result_M = 32'hAA;
        bus.rd_W = 5'd3; bus.RegWrite_W = 1'b1; bus.result_W = 32'hBB;
        #1;
        check("fwd_mem_prio", bus.opA, 32'hAA);
        bus.RegWrite_M = 1'b0;
        #1;
        check("fwd_wb", bus.opA, 32'hBB);
        bus.RegWrite_M = 1'b1; bus.rd_M = 5'd0; bus.rd_W = 5'd0;
        #1;
        check("fwd_rd0", bus.opA, 32'h11);
        check("fwd_x0_rs2", bus.write_data_E, 32'h55);
        check("fwd_x0_opB", bus.opB, 32'h55);
        clear_fwd();
        bus.stall_E = 1'b0;

        // Forwarding on rs2 from WB reaches both store data and opB.
        drive(32'h11, 32'h66, 32'h0, 32'h400, 5'd8, 5'd6, 5'd9, SRC_A_RS1, SRC_B_RS2, 6'd0, 6'b100000);
        tick();
        check_e("fwd2_base");
        bus.stall_E = 1'b1;
        bus.rd_W = 5'd6; bus.RegWrite_W = 1'b1; bus.result_W = 32'hCC;
        #1;
        check("fwd2_wd",  bus.write_data_E, 32'hCC);
        check("fwd2_opB", bus.opB, 32'hCC);
        check("fwd2_opA", bus.opA, 32'h11);
        clear_fwd();

        // Stall holds every field for three edges while D changes.
        bus.rs1_data_D = 32'hDEAD; bus.rs2_data_D = 32'hBEEF; bus.PC_D = 32'h999;
        bus.ctrl_D = 6'b000000; bus.rd_D = 5'd1; bus.ALUControl_D = 6'd7;
        for (int i = 0; i < 3; i++) begin
            hold_expect();
            tick();
            check_e("stall");
        end
        bus.stall_E = 1'b0;

        // Load-use detection.
        drive(32'h1, 32'h2, 32'h3, 32'h500, 5'd0, 5'd0, 5'd4, SRC_A_RS1, SRC_B_IMM, 6'd0, 6'b100001);
        tick();
        check_e("lu_load");
        bus.rs1_D = 5'd0; bus.rs2_D = 5'd4;
        #1;
        check("lu_rs2_hit", 32'(bus.lw_stall), 32'd1);
        bus.rs2_D = 5'd5;
        #1;
        check("lu_miss", 32'(bus.lw_stall), 32'd0);
        bus.rs1_D = 5'd4;
        #1;
        check("lu_rs1_hit", 32'(bus.lw_stall), 32'd1);

        drive(32'h1, 32'h2, 32'h3, 32'h504, 5'd0, 5'd0, 5'd0, SRC_A_RS1, SRC_B_IMM, 6'd0, 6'b100001);
        tick();
        check_e("lu_rd0");
        check("lu_rd0.lw", 32'(bus.lw_stall), 32'd0);

        drive(32'h1, 32'h2, 32'h3, 32'h508, 5'd0, 5'd0, 5'd4, SRC_A_RS1, SRC_B_IMM, 6'd0, 6'b100001);
        tick();
        check_e("lu_load2");
        bus.flush_E = 1'b1;
        bubble_expect();
        tick();
        check_e("flush");
        bus.flush_E = 1'b0;
        bus.rs2_D = 5'd4;
        #1;
        check("flush.lw", 32'(bus.lw_stall), 32'd0);

        // Flush wins over stall.
        drive(32'h77, 32'h88, 32'h99, 32'h600, 5'd1, 5'd2, 5'd3, SRC_A_RS1, SRC_B_RS2, 6'd2, 6'b101110);
        tick();
        check_e("pre_sf");
        bus.stall_E = 1'b1;
        bus.flush_E = 1'b1;
        bubble_expect();
        tick();
        check_e("stall_flush");
        bus.stall_E = 1'b0;
        bus.flush_E = 1'b0;

        // Asynchronous reset between edges, then a normal load.
        drive(32'h31, 32'h32, 32'h33, 32'h700, 5'd1, 5'd2, 5'd3, SRC_A_RS1, SRC_B_RS2, 6'd5, 6'b100001);
        tick();
        check_e("pre_rst");
        #1;
        rst = 1'b1;
        #1;
        check("arst.opA",   bus.opA, 32'h0);
        check("arst.valid", 32'(bus.valid_E), 32'h0);
        check("arst.alu",   32'(bus.ALUControl_E), 32'h0);
        check("arst.pc",    bus.PC_E, 32'h0);
        check("arst.ctrl",  32'(bus.ctrl_E), 32'h0);
        rst = 1'b0;
        drive(32'h41, 32'h42, 32'h43, 32'h800, 5'd1, 5'd2, 5'd3, SRC_A_RS1, SRC_B_IMM, 6'd1, 6'b100000);
        tick();
        check_e("post_rst");

        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
